seq_shift_add_multiplier: RTL and testbench

SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

---
 rtl/seq_shift_add_multiplier.sv | 137 +++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first,
// with two's-complement support. Define SEQ_MULT_EARLY_TERM_EN to finish as soon as no set multiplier bits remain.
module seq_shift_add_multiplier #(
    parameter int Word_Length = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [Word_Length-1:0]     Multiplicand_Input,
    input  logic [Word_Length-1:0]     Multiplier_Input,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [2*Word_Length-1:0]   Product_Output,
    output logic [1:0]                 state_o
);

    localparam int PW    = 2 * Word_Length;
    localparam int CNT_W = $clog2(Word_Length);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Word_Length - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [PW-1:0]          mcand_q;
    logic [Word_Length-1:0] mplier_q;
    logic                   signed_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [PW-1:0]          product_q;
    logic [PW-1:0]          addend;
    logic                   run_last;

    // Handshake: start is taken only on an edge where ready=1; done is a
    // single-cycle pulse during which Product_Output holds the new result.

    // The multiplier register shifts right each RUN edge, so bit 0 is always
    // the bit under processing and the upper bits are the unprocessed ones.
    always_comb begin
        addend = mcand_q << cnt_q;
        acc_d  = acc_q;
        if (mplier_q[0]) begin
            if (signed_q && (cnt_q == LAST_BIT)) begin
                acc_d = acc_q - addend;
            end else begin
                acc_d = acc_q + addend;
            end
        end
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    // A set MSB keeps the remaining bits nonzero, so signed negatives never exit early.
    assign run_last = (cnt_q == LAST_BIT) || ((mplier_q >> 1) == '0);
`else
    assign run_last = (cnt_q == LAST_BIT);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (signed_mode) begin
                            mcand_q <= {{Word_Length{Multiplicand_Input[Word_Length-1]}}, Multiplicand_Input};
                        end else begin
                            mcand_q <= {{Word_Length{1'b0}}, Multiplicand_Input};
                        end
                        mplier_q <= Multiplier_Input;
                        signed_q <= signed_mode;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (run_last) begin
                        product_q <= acc_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Product_Output = product_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (Word_Length=8): hand-computed
// products, done latency, start-ignore behaviour and mid-operation reset.
module tb_seq_shift_add_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   Multiplicand_Input;
    logic [W-1:0]   Multiplier_Input;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] Product_Output;
    logic [1:0]     state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] exp_q[$];

    seq_shift_add_multiplier #(.Word_Length(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .signed_mode        (signed_mode),
        .Multiplicand_Input (Multiplicand_Input),
        .Multiplier_Input   (Multiplier_Input),
        .ready              (ready),
        .busy               (busy),
        .done               (done),
        .Product_Output     (Product_Output),
        .state_o            (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge. lat_full / lat_early: edges from the start edge
    // (counted as 1) until done is seen high, without / with early termination.
    task automatic run_mul(input string tag, input logic sm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] expv,
                           input int lat_full, input int lat_early, input bit poke);
        int n;
        int lat;
        logic [2*W-1:0] e;
`ifdef SEQ_MULT_EARLY_TERM_EN
        lat = lat_early;
`else
        lat = lat_full;
`endif
        exp_q.push_back(expv);
        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        start              = 1'b1;
        signed_mode        = sm;
        Multiplicand_Input = a;
        Multiplier_Input   = b;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = poke;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && n < 40) begin
            if (poke) begin
                start              = 1'b1;
                signed_mode        = ~signed_mode;
                Multiplicand_Input = W'($urandom_range(0, 255));
                Multiplier_Input   = W'($urandom_range(0, 255));
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        e = exp_q.pop_front();
        check({tag, "_product"}, 32'(Product_Output), 32'(e));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check({tag, "_hold"}, 32'(Product_Output), 32'(e));
        if (poke) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_no_restart"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int n;
        rst                = 1'b0;
        start              = 1'b0;
        signed_mode        = 1'b0;
        Multiplicand_Input = '0;
        Multiplier_Input   = '0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(Product_Output), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_mul("s_m5_m7",   1'b1, 8'hFB, 8'hF9, 16'h0023, 9, 9, 1'b0);
        run_mul("s_m128sq",  1'b1, 8'h80, 8'h80, 16'h4000, 9, 9, 1'b0);
        run_mul("u_80_80",   1'b0, 8'h80, 8'h80, 16'h4000, 9, 9, 1'b0);
        run_mul("u_ff_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 9, 9, 1'b0);
        run_mul("s_2_10",    1'b1, 8'h02, 8'h0A, 16'h0014, 9, 5, 1'b0);
        run_mul("s_5_3",     1'b1, 8'h05, 8'h03, 16'h000F, 9, 3, 1'b0);
        run_mul("s_m3_5",    1'b1, 8'hFD, 8'h05, 16'hFFF1, 9, 4, 1'b0);
        run_mul("s_7_m1",    1'b1, 8'h07, 8'hFF, 16'hFFF9, 9, 9, 1'b0);
        run_mul("s_127_m128",1'b1, 8'h7F, 8'h80, 16'hC080, 9, 9, 1'b0);
        run_mul("u_200_0",   1'b0, 8'hC8, 8'h00, 16'h0000, 9, 2, 1'b0);
        run_mul("u_poke",    1'b0, 8'h0D, 8'h0B, 16'h008F, 9, 5, 1'b1);

        // Reset after RUN edge 3 of 127*127
        start              = 1'b1;
        signed_mode        = 1'b0;
        Multiplicand_Input = 8'h7F;
        Multiplier_Input   = 8'h7F;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_product", 32'(Product_Output), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_mul("after_rst_3_4", 1'b0, 8'h03, 8'h04, 16'h000C, 9, 4, 1'b0);

        n = 0;
        while (n < 3) begin
            @(negedge clk);
            n++;
        end
        check("final_idle", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
